// File: rtl/sseg_scanner.sv
// Time-multiplexed common-anode seven-segment driver with frame-synchronous double buffering.
// Build option: define SSEG_HEX_EN to show nibbles 10-15 as hex glyphs instead of a dash.
module sseg_scanner #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic                    load,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [7:0]              sseg,
    output logic                    frame_start
);

    localparam int TW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    logic [4*NUM_DIGITS-1:0] pend_digits, act_digits, nxt_digits;
    logic [NUM_DIGITS-1:0]   pend_dp, act_dp, nxt_dp;
    logic [NUM_DIGITS-1:0]   pend_blank, act_blank, nxt_blank;

    logic [TW-1:0]         tick_cnt;
    logic [IW-1:0]         idx;
    logic [3:0]            sel_nib;
    logic                  sel_dp;
    logic                  sel_blank;
    logic [NUM_DIGITS-1:0] an_sel;

    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b0000001;
            4'h1:    seg = 7'b1001111;
            4'h2:    seg = 7'b0010010;
            4'h3:    seg = 7'b0000110;
            4'h4:    seg = 7'b1001100;
            4'h5:    seg = 7'b0100100;
            4'h6:    seg = 7'b0100000;
            4'h7:    seg = 7'b0001111;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0000100;
`ifdef SSEG_HEX_EN
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b1100000;
            4'hC:    seg = 7'b0110001;
            4'hD:    seg = 7'b1000010;
            4'hE:    seg = 7'b0110000;
            4'hF:    seg = 7'b0111000;
            default: seg = 7'b1111111;
`else
            default: seg = 7'b1111110;
`endif
        endcase
        return seg;
    endfunction

    // frame_start is high while the dead cycle of slot 0 is on the pins; that cycle is
    // the frame boundary, so a load in it bypasses pending and lands in this frame.
    always_comb begin
        nxt_digits = act_digits;
        nxt_dp     = act_dp;
        nxt_blank  = act_blank;
        if (frame_start) begin
            if (load) begin
                nxt_digits = digits;
                nxt_dp     = dp;
                nxt_blank  = blank;
            end else begin
                nxt_digits = pend_digits;
                nxt_dp     = pend_dp;
                nxt_blank  = pend_blank;
            end
        end
    end

    always_comb begin
        sel_nib   = 4'h0;
        sel_dp    = 1'b0;
        sel_blank = 1'b1;
        an_sel    = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                sel_nib   = nxt_digits[4*i +: 4];
                sel_dp    = nxt_dp[i];
                sel_blank = nxt_blank[i];
                an_sel[i] = 1'b0;
            end
        end
    end

    // tick_cnt/idx name the slot position the outputs will show after the next edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_digits <= '0;
            pend_dp     <= '0;
            pend_blank  <= '1;
            act_digits  <= '0;
            act_dp      <= '0;
            act_blank   <= '1;
            tick_cnt    <= '0;
            idx         <= '0;
            an          <= '1;
            sseg        <= 8'hFF;
            frame_start <= 1'b0;
        end else begin
            if (load) begin
                pend_digits <= digits;
                pend_dp     <= dp;
                pend_blank  <= blank;
            end
            act_digits <= nxt_digits;
            act_dp     <= nxt_dp;
            act_blank  <= nxt_blank;

            if (tick_cnt == TICK_LAST) begin
                tick_cnt <= '0;
                idx      <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
            end else begin
                tick_cnt <= tick_cnt + TW'(1);
            end

            frame_start <= (tick_cnt == '0) && (idx == '0);

            if ((tick_cnt == '0) || sel_blank) begin
                an   <= '1;
                sseg <= 8'hFF;
            end else begin
                an   <= an_sel;
                sseg <= {~sel_dp, decode(sel_nib)};
            end
        end
    end

endmodule

// File: tb/tb_sseg_scanner.sv
// Bench for sseg_scanner (4 digits, 4-cycle slots): frame-position reference model plus directed frames.
module tb_sseg_scanner;

    localparam int N  = 4;
    localparam int R  = 4;
    localparam int NR = N * R;

    localparam logic [6:0] SEG_TBL [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
        7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100,
`ifdef SSEG_HEX_EN
        7'b0001000, 7'b1100000, 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
`else
        7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110
`endif
    };

`ifdef SSEG_HEX_EN
    localparam logic [7:0] HEX_D0 = 8'hB8;
    localparam logic [7:0] HEX_D1 = 8'h88;
`else
    localparam logic [7:0] HEX_D0 = 8'hFE;
    localparam logic [7:0] HEX_D1 = 8'hFE;
`endif

    // clock / reset
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [4*N-1:0] digits = '0;
    logic [N-1:0]   dp     = '0;
    logic [N-1:0]   blank  = '0;
    logic           load   = 1'b0;
    logic [N-1:0]   an;
    logic [7:0]     sseg;
    logic           frame_start;

    sseg_scanner #(.NUM_DIGITS(N), .REFRESH_DIV(R)) dut (
        .clk(clk),
        .reset(reset),
        .digits(digits),
        .dp(dp),
        .blank(blank),
        .load(load),
        .an(an),
        .sseg(sseg),
        .frame_start(frame_start)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference model: position within the frame, pending and active images
    int          pos = -1;
    logic [15:0] m_pd = '0, m_ad = '0;
    logic [3:0]  m_pdp = '0, m_adp = '0, m_pb = '1, m_ab = '1;
    logic [12:0] exp_q[$];

    task automatic model_step();
        int s;
        int t;
        logic [3:0] e_an;
        logic [7:0] e_seg;
        if (reset) begin
            pos  = -1;
            m_pd = '0; m_pdp = '0; m_pb = '1;
            m_ad = '0; m_adp = '0; m_ab = '1;
        end else begin
            if (pos == 0) begin
                if (load) begin
                    m_ad = digits; m_adp = dp; m_ab = blank;
                end else begin
                    m_ad = m_pd; m_adp = m_pdp; m_ab = m_pb;
                end
            end
            if (load) begin
                m_pd = digits; m_pdp = dp; m_pb = blank;
            end
            pos = (pos + 1) % NR;
        end
        if (pos < 0) begin
            exp_q.push_back({1'b0, 4'hF, 8'hFF});
        end else begin
            s = pos / R;
            t = pos % R;
            if (t == 0 || m_ab[s]) begin
                e_an  = 4'hF;
                e_seg = 8'hFF;
            end else begin
                e_an  = ~(4'b0001 << s);
                e_seg = {~m_adp[s], SEG_TBL[m_ad[4*s +: 4]]};
            end
            exp_q.push_back({(pos == 0), e_an, e_seg});
        end
    endtask

    always @(posedge clk) model_step();

    // scoreboard: compare every cycle away from the active edge
    always @(negedge clk) begin
        logic [12:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("frame_start", {15'h0, frame_start}, {15'h0, e[12]});
            check("an", {12'h0, an}, {12'h0, e[11:8]});
            check("sseg", {8'h00, sseg}, {8'h00, e[7:0]});
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
        digits = d;
        dp     = p;
        blank  = b;
        load   = 1'b1;
        step();
        load   = 1'b0;
    endtask

    task automatic wait_fs();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            found = (frame_start === 1'b1);
        end
        check("fs_seen", {15'h0, found}, 16'h1);
    endtask

    // expects to be called at frame position 1; returns at the next frame_start
    task automatic check_frame(input logic [31:0] lit);
        for (int k = 1; k < NR; k++) begin
            int s;
            int t;
            logic [3:0] ea;
            logic [7:0] es;
            s  = k / R;
            t  = k % R;
            ea = (t == 0) ? 4'hF : ~(4'b0001 << s);
            es = (t == 0) ? 8'hFF : lit[8*s +: 8];
            check("dir_an", {12'h0, an}, {12'h0, ea});
            check("dir_sseg", {8'h00, sseg}, {8'h00, es});
            step();
        end
    endtask

    initial begin
        repeat (3) step();
        reset = 1'b0;
        repeat (36) step();

        wait_fs();
        step();
        do_load(16'h4321, 4'b0100, 4'b0000);
        wait_fs();
        step();
        check_frame({8'hCC, 8'h06, 8'h92, 8'hCF});

        repeat (9) step();
        do_load(16'h9999, 4'b0000, 4'b0000);
        wait_fs();
        step();
        check_frame({8'h84, 8'h84, 8'h84, 8'h84});

        do_load(16'h0008, 4'b0000, 4'b0000);
        check_frame({8'h81, 8'h81, 8'h81, 8'h80});

        do_load(16'h1111, 4'b0000, 4'b1010);
        for (int k = 1; k < NR; k++) begin
            int s;
            s = k / R;
            check("blank_an13", {14'h0, an[3], an[1]}, 16'h3);
            if (s == 1 || s == 3) check("blank_sseg", {8'h00, sseg}, 16'h00FF);
            step();
        end

        do_load(16'h00AF, 4'b0000, 4'b0000);
        check("hex_d0", {8'h00, sseg}, {8'h00, HEX_D0});
        repeat (4) step();
        check("hex_d1", {8'h00, sseg}, {8'h00, HEX_D1});
        step();
        reset = 1'b1;
        step();
        check("rst_an", {12'h0, an}, 16'h000F);
        check("rst_sseg", {8'h00, sseg}, 16'h00FF);
        step();
        reset = 1'b0;

        for (int c = 0; c < 600; c++) begin
            reset = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 5) == 0) begin
                digits = 16'($urandom);
                dp     = 4'($urandom_range(0, 15));
                blank  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
                load   = 1'b1;
            end else begin
                load   = 1'b0;
            end
            step();
        end
        reset = 1'b0;
        load  = 1'b0;
        repeat (20) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
